serial_subtractor: RTL

- Bit-serial two's-complement subtractor that computes DIFF = A - B - BIN, processing one bit per clock, LSB first.
- The datapath is a single full-subtractor cell (difference = XOR of three inputs, borrow = ~a&b | ~(a^b)&bin) feeding a registered borrow flip-flop.
- It is the subtraction counterpart to the team's half-adder/full-adder arithmetic cells, for area-constrained datapaths where latency is acceptable.
- Interface is start/busy/done; operands are captured at start.

---
 rtl/serial_subtractor.sv | 116 +++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial A - B - BIN, one bit per clock, LSB first
module serial_subtractor #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             ovf
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic               brw_q, brw_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               a_msb_q, a_msb_d;
  logic               b_msb_q, b_msb_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               borrow_q, borrow_d;
  logic               ovf_q, ovf_d;

  logic d_bit;
  logic brw_nx;

  // Full-subtractor cell on the current LSBs.
  assign d_bit  = a_sh_q[0] ^ b_sh_q[0] ^ brw_q;
  assign brw_nx = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & brw_q);

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    brw_d    = brw_q;
    cnt_d    = cnt_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          brw_d   = bin;
          cnt_d   = '0;
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // Difference bits refill the minuend register from the top as it drains.
        a_sh_d = {d_bit, a_sh_q[WIDTH-1:1]};
        b_sh_d = b_sh_q >> 1;
        brw_d  = brw_nx;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH-1)) begin
          diff_d   = {d_bit, a_sh_q[WIDTH-1:1]};
          borrow_d = brw_nx;
          ovf_d    = (a_msb_q != b_msb_q) && (d_bit != a_msb_q);
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      brw_q    <= 1'b0;
      cnt_q    <= '0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      brw_q    <= brw_d;
      cnt_q    <= cnt_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign diff       = diff_q;
  assign borrow_out = borrow_q;
  assign ovf        = ovf_q;

endmodule
